pc_ras: RTL and testbench

PC_RAS -- requirements
Module: pc_ras

---
 rtl/pc_pkg.sv | 17 +
 rtl/ras_stack.sv | 51 +++++
 rtl/pc_ras.sv | 85 ++++++++
 tb/tb_pc_ras.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared defaults and operation select for the program counter
package pc_pkg;

   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_DEPTH      = 4;
   localparam int DEF_RESET_ADDR = 0;

   typedef enum logic [2:0] {
      HOLD,
      RET,
      CALL,
      JMP,
      REL,
      INC
   } pc_op_e;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - return-address LIFO with registered depth
module ras_stack #(
   parameter int W     = 5,
   parameter int DEPTH = 4,
   parameter int DW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  push_data,
   output logic [W-1:0]  top,
   output logic [DW-1:0] depth,
   output logic          full,
   output logic          empty
);

   logic [W-1:0] mem [DEPTH];

   assign full  = (depth == DW'(DEPTH));
   assign empty = (depth == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         depth <= '0;
      end else if (push && !full) begin
         depth <= depth + DW'(1);
      end else if (pop && !empty) begin
         depth <= depth - DW'(1);
      end
   end

   // Entry contents are never reset; depth alone decides what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!rst && push && !full && depth == DW'(i)) begin
            mem[i] <= push_data;
         end
      end
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (depth == DW'(i + 1)) begin
            top = mem[i];
         end
      end
   end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with jump/branch/call/return and return-address stack
module pc_ras
   import pc_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int RESET_ADDR = DEF_RESET_ADDR
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic                       jmp_en_i,
   input  logic [ADDR_W-1:0]          jmp_addr_i,
   input  logic                       rel_en_i,
   input  logic [ADDR_W-1:0]          rel_off_i,
   input  logic                       call_en_i,
   input  logic                       ret_en_i,
   output logic [ADDR_W-1:0]          addr_o,
   output logic [$clog2(DEPTH+1)-1:0] depth_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       ovf_o,
   output logic                       unf_o
);

   pc_op_e            op;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] top;
   logic [ADDR_W-1:0] addr_inc;

   assign addr_inc = addr_o + ADDR_W'(1);

   always_comb begin
      op = INC;
      if (!en_i)          op = HOLD;
      else if (ret_en_i)  op = RET;
      else if (call_en_i) op = CALL;
      else if (jmp_en_i)  op = JMP;
      else if (rel_en_i)  op = REL;
   end

   // A rejected call or return must leave the stack untouched as well as the address.
   assign push = (op == CALL) && !full_o;
   assign pop  = (op == RET) && !empty_o;

   ras_stack #(
      .W     (ADDR_W),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .pop       (pop),
      .push_data (addr_inc),
      .top       (top),
      .depth     (depth_o),
      .full      (full_o),
      .empty     (empty_o)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_o <= ADDR_W'(RESET_ADDR);
         ovf_o  <= 1'b0;
         unf_o  <= 1'b0;
      end else begin
         case (op)
            RET: begin
               if (pop) addr_o <= top;
               else     unf_o  <= 1'b1;
            end
            CALL: begin
               if (push) addr_o <= jmp_addr_i;
               else      ovf_o  <= 1'b1;
            end
            JMP:     addr_o <= jmp_addr_i;
            REL:     addr_o <= addr_o + rel_off_i;
            INC:     addr_o <= addr_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - randomized and directed check of pc_ras against a queue-based model
module tb_pc_ras;

   localparam int AW = 5;
   localparam int D  = 4;
   localparam int MOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          en_i = 1'b0;
   logic          jmp_en_i = 1'b0;
   logic [AW-1:0] jmp_addr_i = '0;
   logic          rel_en_i = 1'b0;
   logic [AW-1:0] rel_off_i = '0;
   logic          call_en_i = 1'b0;
   logic          ret_en_i = 1'b0;
   logic [AW-1:0] addr_o;
   logic [2:0]    depth_o;
   logic          full_o, empty_o, ovf_o, unf_o;

   int checks = 0;
   int errors = 0;

   int m_addr = 0;
   int m_stk[$];
   int m_ovf = 0;
   int m_unf = 0;

   pc_ras #(.ADDR_W(AW), .DEPTH(D), .RESET_ADDR(0)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .jmp_en_i   (jmp_en_i),
      .jmp_addr_i (jmp_addr_i),
      .rel_en_i   (rel_en_i),
      .rel_off_i  (rel_off_i),
      .call_en_i  (call_en_i),
      .ret_en_i   (ret_en_i),
      .addr_o     (addr_o),
      .depth_o    (depth_o),
      .full_o     (full_o),
      .empty_o    (empty_o),
      .ovf_o      (ovf_o),
      .unf_o      (unf_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour: the highest-priority request wins, the stack is a plain queue.
   task automatic model_step();
      if (rst_i) begin
         m_addr = 0;
         m_stk.delete();
         m_ovf = 0;
         m_unf = 0;
      end else if (en_i) begin
         if (ret_en_i) begin
            if (m_stk.size() > 0) m_addr = m_stk.pop_back();
            else                  m_unf = 1;
         end else if (call_en_i) begin
            if (m_stk.size() < D) begin
               m_stk.push_back((m_addr + 1) % MOD);
               m_addr = int'(jmp_addr_i);
            end else begin
               m_ovf = 1;
            end
         end else if (jmp_en_i) begin
            m_addr = int'(jmp_addr_i);
         end else if (rel_en_i) begin
            m_addr = (m_addr + int'(rel_off_i)) % MOD;
         end else begin
            m_addr = (m_addr + 1) % MOD;
         end
      end
   endtask

   task automatic compare_all();
      check("addr", int'(addr_o), m_addr);
      check("depth", int'(depth_o), m_stk.size());
      check("full", int'(full_o), int'(m_stk.size() == D));
      check("empty", int'(empty_o), int'(m_stk.size() == 0));
      check("ovf", int'(ovf_o), m_ovf);
      check("unf", int'(unf_o), m_unf);
   endtask

   task automatic step(input logic rst, input logic en, input logic jmp, input int ja,
                       input logic rel, input int ro, input logic call, input logic ret);
      rst_i      = rst;
      en_i       = en;
      jmp_en_i   = jmp;
      jmp_addr_i = AW'(ja);
      rel_en_i   = rel;
      rel_off_i  = AW'(ro);
      call_en_i  = call;
      ret_en_i   = ret;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle();     step(0, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic jump(input int a); step(0, 1, 1, a, 0, 0, 0, 0); endtask
   task automatic call(input int a); step(0, 1, 0, a, 0, 0, 1, 0); endtask
   task automatic ret();      step(0, 1, 0, 0, 0, 0, 0, 1); endtask
   task automatic reset();    step(1, 1, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      // Reset and free-running increment
      reset();
      reset();
      check("rst_addr", int'(addr_o), 0);
      check("rst_empty", int'(empty_o), 1);
      for (int i = 1; i <= 3; i++) begin
         idle();
         check("inc_seq", int'(addr_o), i);
      end
      check("inc_empty", int'(empty_o), 1);

      // Wrap on increment and negative relative branch
      jump(31);
      idle();
      check("inc_wrap", int'(addr_o), 0);
      jump(2);
      step(0, 1, 0, 0, 1, 5'b11110, 0, 0);
      check("rel_neg", int'(addr_o), 0);

      // Single call/return
      jump(3);
      call(25);
      check("call_addr", int'(addr_o), 25);
      check("call_depth", int'(depth_o), 1);
      ret();
      check("ret_addr", int'(addr_o), 4);
      check("ret_empty", int'(empty_o), 1);

      // Nested calls to overflow, unwind to underflow
      jump(10);
      call(1); call(2); call(3); call(4);
      check("nest_depth", int'(depth_o), 4);
      check("nest_full", int'(full_o), 1);
      call(7);
      check("ovf_addr", int'(addr_o), 4);
      check("ovf_flag", int'(ovf_o), 1);
      ret(); check("unwind0", int'(addr_o), 4);
      ret(); check("unwind1", int'(addr_o), 3);
      ret(); check("unwind2", int'(addr_o), 2);
      ret(); check("unwind3", int'(addr_o), 11);
      ret();
      check("unf_addr", int'(addr_o), 11);
      check("unf_flag", int'(unf_o), 1);
      check("ovf_sticky", int'(ovf_o), 1);

      // Priority and stall
      reset();
      jump(8);
      call(20);
      step(0, 1, 1, 17, 0, 0, 1, 1);
      check("prio_ret", int'(addr_o), 9);
      check("prio_depth", int'(depth_o), 0);
      step(0, 0, 1, 30, 1, 3, 1, 1);
      check("stall_addr", int'(addr_o), 9);

      // Reset in the middle of nested calls
      call(12); call(13); call(14);
      step(1, 1, 0, 5, 0, 0, 1, 0);
      check("mid_rst_addr", int'(addr_o), 0);
      check("mid_rst_depth", int'(depth_o), 0);
      check("mid_rst_ovf", int'(ovf_o), 0);
      check("mid_rst_unf", int'(unf_o), 0);

      // Random traffic, call/return biased so the stack sees both edges
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, MOD - 1)),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, MOD - 1)),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 2) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
